// File: rtl/u2s_tx_drain_if.sv
// Bundle between the drain engine and its buffer RAM, writer and UART pin.
// master = drain engine, slave = RAM/writer/line side.
interface u2s_tx_drain_if;
    logic [9:0] Wr_Ptr;
    logic [9:0] Rd_Ptr;
    logic [8:0] RA;
    logic       RClk_En;
    logic [7:0] RD;
    logic       Tx_En;
    logic       Txd;
    logic       Tx_Busy;
    logic       Empty;

    modport master (
        input  Wr_Ptr, RD, Tx_En,
        output Rd_Ptr, RA, RClk_En, Txd, Tx_Busy, Empty
    );

    modport slave (
        output Wr_Ptr, RD, Tx_En,
        input  Rd_Ptr, RA, RClk_En, Txd, Tx_Busy, Empty
    );
endinterface

// File: rtl/u2s_tx_drain.sv
// Read-side drain of the 512x8 transmit buffer: fetches bytes from the RAM
// and shifts them out as 8N1 UART frames, LSB first.
module u2s_tx_drain #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic Clk,
    input  logic Rst_n,
    u2s_tx_drain_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [9:0]  rd_ptr;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic        txd;
    logic        busy;
    logic        rclk_en;
    logic        empty;
    logic        bit_end;
    logic        go;

    assign empty       = (bus.Wr_Ptr == rd_ptr);
    assign go          = bus.Tx_En && !empty;
    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign bus.Empty   = empty;
    assign bus.Rd_Ptr  = rd_ptr;
    assign bus.RA      = rd_ptr[8:0];
    assign bus.RClk_En = rclk_en;
    assign bus.Txd     = txd;
    assign bus.Tx_Busy = busy;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            rclk_en  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state   <= FETCH;
                        rclk_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    state   <= LOAD;
                    rclk_en <= 1'b0;
                end
                LOAD: begin
                    shreg    <= bus.RD;
                    rd_ptr   <= rd_ptr + 10'd1;
                    txd      <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        // Start decision re-evaluated here for back-to-back frames
                        if (go) begin
                            state   <= FETCH;
                            rclk_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    rclk_en <= 1'b0;
                    txd     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_u2s_tx_drain.sv
// Bench for u2s_tx_drain: RAM model, UART frame scoreboard and directed tests.
// Expected bytes are queued by the stimulus and checked by a line monitor.
module tb_u2s_tx_drain;
    localparam int CPB = 4;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    u2s_tx_drain_if bus ();

    u2s_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [512];
    logic [7:0] rd_q;

    always @(posedge Clk) begin
        if (bus.RClk_En) rd_q <= mem[bus.RA];
    end
    assign bus.RD = rd_q;

    int checks = 0;
    int errors = 0;
    int last_gap = 0;
    logic [7:0] exp_q [$];
    int ra_log [$];
    int ptr_log [$];
    logic [9:0] prev_ptr;

    always @(negedge Clk) begin
        if (Rst_n && bus.RClk_En) ra_log.push_back(int'(bus.RA));
        if (bus.Rd_Ptr !== prev_ptr) ptr_log.push_back(int'(bus.Rd_Ptr));
        prev_ptr = bus.Rd_Ptr;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        repeat (3) @(negedge Clk);
        while (bus.Tx_Busy && n < maxc) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (bus.Tx_Busy) begin
            errors++;
            $display("FAIL idle_timeout got busy=1 expected busy=0");
        end
    endtask

    task automatic wait_txd_low(input int maxc);
        int n = 0;
        @(negedge Clk);
        while (bus.Txd && n < maxc) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (bus.Txd) begin
            errors++;
            $display("FAIL start_timeout got txd=1 expected txd=0");
        end
    endtask

    // Line monitor: checks every cycle of every frame against the queued byte
    initial begin : monitor
        int run;
        logic [9:0] fr;
        logic [7:0] b;
        bit bad;
        bit abort;
        run = 0;
        wait (Rst_n === 1'b1);
        forever begin
            @(negedge Clk);
            if (Rst_n !== 1'b1) begin
                run = 0;
            end else if (bus.Txd !== 1'b0) begin
                run++;
            end else begin
                last_gap = run;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame got start expected idle");
                    fr = {1'b1, 8'h00, 1'b0};
                end else begin
                    fr = {1'b1, exp_q.pop_front(), 1'b0};
                end
                bad = 0;
                abort = 0;
                b = '0;
                for (int i = 0; i < 10; i++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!abort) begin
                            if (!(i == 0 && c == 0)) @(negedge Clk);
                            if (Rst_n !== 1'b1) begin
                                abort = 1;
                            end else begin
                                if (bus.Txd !== fr[i]) bad = 1;
                                if (c == CPB / 2 && i >= 1 && i <= 8)
                                    b[i-1] = bus.Txd;
                            end
                        end
                    end
                end
                if (abort) begin
                    run = 0;
                end else begin
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL frame got byte 0x%0h expected 0x%0h (bit timing or framing)",
                                 b, fr[8:1]);
                    end
                    run = CPB;
                end
            end
        end
    end

    initial begin : stim
        int lows;
        bus.Wr_Ptr = '0;
        bus.Tx_En  = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        mem[3] = 8'h81;
        mem[4] = 8'h6E;
        for (int i = 5; i < 511; i++) mem[i] = 8'(i * 7 + 3);
        mem[511] = 8'h3C;

        repeat (3) @(negedge Clk);
        chk("rst_txd", int'(bus.Txd), 1);
        chk("rst_busy", int'(bus.Tx_Busy), 0);
        chk("rst_ptr", int'(bus.Rd_Ptr), 0);
        chk("rst_rclk", int'(bus.RClk_En), 0);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        chk("post_rst_txd", int'(bus.Txd), 1);
        chk("post_rst_busy", int'(bus.Tx_Busy), 0);
        chk("post_rst_ptr", int'(bus.Rd_Ptr), 0);
        chk("post_rst_rclk", int'(bus.RClk_En), 0);
        chk("post_rst_empty", int'(bus.Empty), 1);
        chk("post_rst_ra_log", ra_log.size(), 0);

        // Single byte
        ra_log.delete();
        exp_q.push_back(8'hA5);
        bus.Wr_Ptr = 10'd1;
        bus.Tx_En  = 1'b1;
        wait_txd_low(10);
        chk("single_ptr_at_start", int'(bus.Rd_Ptr), 1);
        chk("single_empty_at_start", int'(bus.Empty), 1);
        wait_idle(100);
        chk("single_rclk_pulses", ra_log.size(), 1);
        if (ra_log.size() > 0) chk("single_ra", ra_log[0], 0);
        chk("single_busy", int'(bus.Tx_Busy), 0);
        chk("single_ptr", int'(bus.Rd_Ptr), 1);

        // Back-to-back
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        bus.Wr_Ptr = 10'd3;
        wait_idle(200);
        chk("b2b_gap", last_gap, CPB + 2);
        chk("b2b_ptr", int'(bus.Rd_Ptr), 3);
        chk("b2b_empty", int'(bus.Empty), 1);

        // Tx_En gating
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h6E);
        bus.Wr_Ptr = 10'd5;
        wait_txd_low(10);
        repeat (CPB + 2) @(negedge Clk);
        bus.Tx_En = 1'b0;
        wait_idle(200);
        chk("gate_ptr", int'(bus.Rd_Ptr), 4);
        chk("gate_empty", int'(bus.Empty), 0);
        chk("gate_rclk", int'(bus.RClk_En), 0);
        repeat (20) @(negedge Clk);
        chk("gate_hold_busy", int'(bus.Tx_Busy), 0);
        chk("gate_hold_ptr", int'(bus.Rd_Ptr), 4);
        bus.Tx_En = 1'b1;
        @(negedge Clk);
        chk("gate_resume", int'(bus.RClk_En), 1);
        wait_idle(200);
        chk("gate_final_ptr", int'(bus.Rd_Ptr), 5);

        // Drain up to 0x1FF
        for (int i = 5; i < 511; i++) exp_q.push_back(8'(i * 7 + 3));
        bus.Wr_Ptr = 10'h1FF;
        wait_idle(30000);
        chk("drain_ptr", int'(bus.Rd_Ptr), 'h1FF);
        chk("drain_queue", exp_q.size(), 0);

        // Wrap
        ra_log.delete();
        ptr_log.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hA5);
        bus.Wr_Ptr = 10'h201;
        wait_idle(300);
        chk("wrap_ra_count", ra_log.size(), 2);
        if (ra_log.size() == 2) begin
            chk("wrap_ra0", ra_log[0], 'h1FF);
            chk("wrap_ra1", ra_log[1], 'h000);
        end
        chk("wrap_ptr_steps", ptr_log.size(), 2);
        if (ptr_log.size() == 2) begin
            chk("wrap_ptr0", ptr_log[0], 'h200);
            chk("wrap_ptr1", ptr_log[1], 'h201);
        end
        chk("wrap_empty", int'(bus.Empty), 1);

        // Reset during data bit 3
        exp_q.push_back(8'h00);
        bus.Wr_Ptr = 10'h202;
        wait_txd_low(10);
        repeat (4 * CPB + 1) @(negedge Clk);
        chk("mid_txd_before", int'(bus.Txd), 0);
        #1;
        Rst_n = 1'b0;
        bus.Wr_Ptr = '0;
        #1;
        chk("mid_rst_txd", int'(bus.Txd), 1);
        chk("mid_rst_ptr", int'(bus.Rd_Ptr), 0);
        chk("mid_rst_busy", int'(bus.Tx_Busy), 0);
        chk("mid_rst_rclk", int'(bus.RClk_En), 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        ra_log.delete();
        lows = 0;
        repeat (30) begin
            @(negedge Clk);
            if (bus.Txd !== 1'b1) lows++;
        end
        chk("post_mid_txd_lows", lows, 0);
        chk("post_mid_rclk", ra_log.size(), 0);
        chk("post_mid_ptr", int'(bus.Rd_Ptr), 0);
        chk("post_mid_busy", int'(bus.Tx_Busy), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
